// File: rtl/tlb_ctrl_pkg.sv
// Shared TLB definitions: opcodes, FSM states, 78-bit entry layout and
// conversions between the packed entry and the CP0 register formats.
package tlb_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_TLBP  = 2'b00,
    OP_TLBR  = 2'b01,
    OP_TLBWI = 2'b10,
    OP_TLBWR = 2'b11
  } tlb_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } tlb_state_e;

  localparam int unsigned TLB_ENTRIES = 16;
  localparam int unsigned TLB_IDX_W   = 4;
  localparam int unsigned ENTRY_W     = 78;

  localparam int unsigned VPN2_HI = 77;
  localparam int unsigned VPN2_LO = 59;
  localparam int unsigned ASID_HI = 58;
  localparam int unsigned ASID_LO = 51;
  localparam int unsigned G_BIT   = 50;
  localparam int unsigned PFN0_HI = 49;
  localparam int unsigned PFN0_LO = 30;
  localparam int unsigned C0_HI   = 29;
  localparam int unsigned C0_LO   = 27;
  localparam int unsigned D0_BIT  = 26;
  localparam int unsigned V0_BIT  = 25;
  localparam int unsigned PFN1_HI = 24;
  localparam int unsigned PFN1_LO = 5;
  localparam int unsigned C1_HI   = 4;
  localparam int unsigned C1_LO   = 2;
  localparam int unsigned D1_BIT  = 1;
  localparam int unsigned V1_BIT  = 0;

  // The entry holds a single G bit, so it is set only when both halves are global.
  function automatic logic [ENTRY_W-1:0] pack_entry(input logic [31:0] hi,
                                                    input logic [31:0] lo0,
                                                    input logic [31:0] lo1);
    logic [ENTRY_W-1:0] e;
    e                    = '0;
    e[VPN2_HI:VPN2_LO]   = hi[31:13];
    e[ASID_HI:ASID_LO]   = hi[7:0];
    e[G_BIT]             = lo0[0] & lo1[0];
    e[PFN0_HI:PFN0_LO]   = lo0[25:6];
    e[C0_HI:C0_LO]       = lo0[5:3];
    e[D0_BIT]            = lo0[2];
    e[V0_BIT]            = lo0[1];
    e[PFN1_HI:PFN1_LO]   = lo1[25:6];
    e[C1_HI:C1_LO]       = lo1[5:3];
    e[D1_BIT]            = lo1[2];
    e[V1_BIT]            = lo1[1];
    return e;
  endfunction

  function automatic logic [31:0] entryhi_of(input logic [ENTRY_W-1:0] e);
    return {e[VPN2_HI:VPN2_LO], 5'b0, e[ASID_HI:ASID_LO]};
  endfunction

  function automatic logic [31:0] entrylo0_of(input logic [ENTRY_W-1:0] e);
    return {6'b0, e[PFN0_HI:PFN0_LO], e[C0_HI:C0_LO], e[D0_BIT], e[V0_BIT], e[G_BIT]};
  endfunction

  function automatic logic [31:0] entrylo1_of(input logic [ENTRY_W-1:0] e);
    return {6'b0, e[PFN1_HI:PFN1_LO], e[C1_HI:C1_LO], e[D1_BIT], e[V1_BIT], e[G_BIT]};
  endfunction

endpackage

// File: rtl/tlb_ctrl.sv
// TLB instruction sequencer: accepts TLBP/TLBR/TLBWI/TLBWR from MEM1 and runs
// each as an atomic IDLE -> EXEC -> WB sequence against the TLB and CP0.
module tlb_ctrl
  import tlb_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         op_valid,
  input  logic [1:0]   op_code,
  input  logic         flush,
  output logic         op_stall,
  output logic         op_done,
  input  logic [31:0]  cp0_entryhi,
  input  logic [31:0]  cp0_entrylo0,
  input  logic [31:0]  cp0_entrylo1,
  input  logic [31:0]  cp0_index,
  input  logic [31:0]  cp0_random,
  output logic         index_wren,
  output logic [31:0]  index_wdata,
  output logic         probe_found,
  output logic         entryhi_wren,
  output logic [31:0]  entryhi_wdata,
  output logic         entrylo0_wren,
  output logic [31:0]  entrylo0_wdata,
  output logic         entrylo1_wren,
  output logic [31:0]  entrylo1_wdata,
  output logic [18:0]  s_vpn2,
  output logic [7:0]   s_asid,
  input  logic         s_found,
  input  logic [3:0]   s_index,
  output logic [3:0]   r_index,
  input  logic [77:0]  r_entry,
  output logic         w_en,
  output logic [3:0]   w_index,
  output logic [77:0]  w_entry
);

  tlb_state_e             state_q, state_d;
  tlb_op_e                op_q;
  logic [31:0]            ehi_q, lo0_q, lo1_q;
  logic [TLB_IDX_W-1:0]   idx_q, rnd_q;
  logic                   found_q;
  logic [TLB_IDX_W-1:0]   sidx_q;
  logic [ENTRY_W-1:0]     rentry_q;
  logic                   accept;
  logic                   unused_bits;

  assign accept = (state_q == S_IDLE) & op_valid & ~flush;

  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_EXEC;
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes are also gated by rst so a reset landing in EXEC/WB emits nothing.
  always_comb begin
    op_stall      = 1'b0;
    op_done       = 1'b0;
    w_en          = 1'b0;
    index_wren    = 1'b0;
    probe_found   = 1'b0;
    entryhi_wren  = 1'b0;
    entrylo0_wren = 1'b0;
    entrylo1_wren = 1'b0;
    if (rst) begin
      case (state_q)
        S_IDLE: op_stall = accept;
        S_EXEC: begin
          op_stall = 1'b1;
          w_en     = (op_q == OP_TLBWI) | (op_q == OP_TLBWR);
        end
        S_WB: begin
          op_done = 1'b1;
          if (op_q == OP_TLBP) begin
            index_wren  = 1'b1;
            probe_found = found_q;
          end
          if (op_q == OP_TLBR) begin
            entryhi_wren  = 1'b1;
            entrylo0_wren = 1'b1;
            entrylo1_wren = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      op_q     <= OP_TLBP;
      ehi_q    <= '0;
      lo0_q    <= '0;
      lo1_q    <= '0;
      idx_q    <= '0;
      rnd_q    <= '0;
      found_q  <= 1'b0;
      sidx_q   <= '0;
      rentry_q <= '0;
    end else begin
      if (accept) begin
        op_q  <= tlb_op_e'(op_code);
        ehi_q <= cp0_entryhi;
        lo0_q <= cp0_entrylo0;
        lo1_q <= cp0_entrylo1;
        idx_q <= cp0_index[TLB_IDX_W-1:0];
        rnd_q <= cp0_random[TLB_IDX_W-1:0];
      end
      if (state_q == S_EXEC) begin
        found_q  <= s_found;
        sidx_q   <= s_index;
        rentry_q <= r_entry;
      end
    end
  end

  assign s_vpn2         = ehi_q[31:13];
  assign s_asid         = ehi_q[7:0];
  assign r_index        = idx_q;
  assign w_index        = (op_q == OP_TLBWR) ? rnd_q : idx_q;
  assign w_entry        = pack_entry(ehi_q, lo0_q, lo1_q);
  assign index_wdata    = {28'b0, sidx_q};
  assign entryhi_wdata  = entryhi_of(rentry_q);
  assign entrylo0_wdata = entrylo0_of(rentry_q);
  assign entrylo1_wdata = entrylo1_of(rentry_q);

  assign unused_bits = ^{cp0_index[31:TLB_IDX_W], cp0_random[31:TLB_IDX_W],
                         ehi_q[12:8], lo0_q[31:26], lo0_q[0], lo1_q[31:26], lo1_q[0]};

endmodule

// File: tb/tb_tlb_ctrl.sv
// Directed bench for tlb_ctrl with a 16-entry TLB array standing in for the TLB.
module tb_tlb_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         op_valid;
  logic [1:0]   op_code;
  logic         flush;
  logic         op_stall, op_done;
  logic [31:0]  cp0_entryhi, cp0_entrylo0, cp0_entrylo1, cp0_index, cp0_random;
  logic         index_wren, probe_found;
  logic [31:0]  index_wdata;
  logic         entryhi_wren, entrylo0_wren, entrylo1_wren;
  logic [31:0]  entryhi_wdata, entrylo0_wdata, entrylo1_wdata;
  logic [18:0]  s_vpn2;
  logic [7:0]   s_asid;
  logic         s_found;
  logic [3:0]   s_index;
  logic [3:0]   r_index;
  logic [77:0]  r_entry;
  logic         w_en;
  logic [3:0]   w_index;
  logic [77:0]  w_entry;

  logic [77:0]  tlb_mem [16];
  int           total = 0;
  int           bad   = 0;

  logic [31:0]  hi_v, lo0_v, lo1_v;
  logic [77:0]  exp_entry;

  always #5 clk = ~clk;

  always @(posedge clk) if (w_en) tlb_mem[w_index] <= w_entry;
  assign r_entry = tlb_mem[r_index];

  tlb_ctrl dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code), .flush(flush),
    .op_stall(op_stall), .op_done(op_done),
    .cp0_entryhi(cp0_entryhi), .cp0_entrylo0(cp0_entrylo0), .cp0_entrylo1(cp0_entrylo1),
    .cp0_index(cp0_index), .cp0_random(cp0_random),
    .index_wren(index_wren), .index_wdata(index_wdata), .probe_found(probe_found),
    .entryhi_wren(entryhi_wren), .entryhi_wdata(entryhi_wdata),
    .entrylo0_wren(entrylo0_wren), .entrylo0_wdata(entrylo0_wdata),
    .entrylo1_wren(entrylo1_wren), .entrylo1_wdata(entrylo1_wdata),
    .s_vpn2(s_vpn2), .s_asid(s_asid), .s_found(s_found), .s_index(s_index),
    .r_index(r_index), .r_entry(r_entry),
    .w_en(w_en), .w_index(w_index), .w_entry(w_entry)
  );

  task automatic chk(input string tag, input logic [77:0] got, input logic [77:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) tlb_mem[i] = '0;
    rst = 1'b0; op_valid = 1'b0; op_code = 2'b00; flush = 1'b0;
    cp0_entryhi = '0; cp0_entrylo0 = '0; cp0_entrylo1 = '0;
    cp0_index = '0; cp0_random = '0; s_found = 1'b0; s_index = '0;

    // Reset state
    tick(); tick();
    chk("rst_stall", op_stall, 0);
    chk("rst_done", op_done, 0);
    chk("rst_wen", w_en, 0);
    chk("rst_idx_wren", index_wren, 0);
    chk("rst_pfound", probe_found, 0);
    chk("rst_vpn2", s_vpn2, 0);
    rst = 1'b1;
    tick();

    // TLBP hit
    op_valid = 1'b1; op_code = 2'b00; cp0_entryhi = 32'h1234_50AB;
    s_found = 1'b1; s_index = 4'd5;
    #1 chk("p_acc_stall", op_stall, 1);
    tick();
    op_valid = 1'b0; cp0_entryhi = '0;
    #1;
    chk("p_exec_vpn2", s_vpn2, 19'h091A2);
    chk("p_exec_asid", s_asid, 8'hAB);
    chk("p_exec_stall", op_stall, 1);
    chk("p_exec_done", op_done, 0);
    chk("p_exec_idx_wren", index_wren, 0);
    tick();
    s_found = 1'b0; s_index = 4'd0;
    #1;
    chk("p_wb_done", op_done, 1);
    chk("p_wb_stall", op_stall, 0);
    chk("p_wb_idx_wren", index_wren, 1);
    chk("p_wb_pfound", probe_found, 1);
    chk("p_wb_idx_wdata", index_wdata, 32'h5);
    tick();
    chk("p_idle_done", op_done, 0);
    chk("p_idle_idx_wren", index_wren, 0);

    // TLBP miss: op_done on third cycle
    op_valid = 1'b1; op_code = 2'b00; cp0_entryhi = 32'h0000_2011;
    s_found = 1'b0; s_index = 4'd7;
    #1 chk("m_c1_done", op_done, 0);
    tick();
    op_valid = 1'b0;
    #1 chk("m_c2_done", op_done, 0);
    tick();
    chk("m_c3_done", op_done, 1);
    chk("m_wb_idx_wren", index_wren, 1);
    chk("m_wb_pfound", probe_found, 0);
    tick();

    // TLBWR: Random=9, Index=3, G = 1 & 0
    op_valid = 1'b1; op_code = 2'b11; cp0_random = 32'd9; cp0_index = 32'd3;
    cp0_entryhi = 32'h0000_4022; cp0_entrylo0 = 32'h0000_0001; cp0_entrylo1 = 32'h0000_0002;
    #1 chk("wr_acc_wen", w_en, 0);
    tick();
    op_valid = 1'b0; cp0_random = 32'd1;
    #1;
    chk("wr_exec_wen", w_en, 1);
    chk("wr_exec_windex", w_index, 4'd9);
    chk("wr_exec_g", w_entry[50], 1'b0);
    tick();
    chk("wr_wb_wen", w_en, 0);
    chk("wr_wb_done", op_done, 1);
    tick();

    // TLBWI to entry 3 (Index[31] set), then TLBR back-to-back
    hi_v = 32'hABCD_E05A; lo0_v = 32'h0123_4567; lo1_v = 32'h0246_8ACF;
    exp_entry = {hi_v[31:13], hi_v[7:0], 1'b1, lo0_v[25:1], lo1_v[25:1]};
    op_valid = 1'b1; op_code = 2'b10; cp0_index = 32'h8000_0003; cp0_random = 32'd12;
    cp0_entryhi = hi_v; cp0_entrylo0 = lo0_v; cp0_entrylo1 = lo1_v;
    tick();
    op_valid = 1'b0; cp0_entryhi = '0; cp0_entrylo0 = '0; cp0_entrylo1 = '0;
    #1;
    chk("wi_exec_wen", w_en, 1);
    chk("wi_exec_windex", w_index, 4'd3);
    chk("wi_exec_entry", w_entry, exp_entry);
    tick();
    chk("wi_wb_wen", w_en, 0);
    chk("wi_wb_done", op_done, 1);
    tick();
    op_valid = 1'b1; op_code = 2'b01; cp0_index = 32'd3;
    #1 chk("r_b2b_stall", op_stall, 1);
    tick();
    op_valid = 1'b0; cp0_index = 32'd5;
    #1;
    chk("r_exec_rindex", r_index, 4'd3);
    chk("r_exec_ehi_wren", entryhi_wren, 0);
    tick();
    chk("r_wb_ehi_wren", entryhi_wren, 1);
    chk("r_wb_lo0_wren", entrylo0_wren, 1);
    chk("r_wb_lo1_wren", entrylo1_wren, 1);
    chk("r_wb_ehi", entryhi_wdata, hi_v);
    chk("r_wb_lo0", entrylo0_wdata, lo0_v);
    chk("r_wb_lo1", entrylo1_wdata, lo1_v);
    chk("r_wb_idx_wren", index_wren, 0);
    tick();
    chk("r_idle_ehi_wren", entryhi_wren, 0);

    // Flush in IDLE blocks acceptance
    op_valid = 1'b1; op_code = 2'b10; flush = 1'b1;
    #1 chk("f_idle_stall", op_stall, 0);
    tick();
    chk("f_idle2_wen", w_en, 0);
    chk("f_idle2_stall", op_stall, 0);
    op_valid = 1'b0; flush = 1'b0;
    tick();
    chk("f_idle3_done", op_done, 0);

    // Flush during EXEC is ignored
    op_valid = 1'b1; op_code = 2'b00; s_found = 1'b1; s_index = 4'd2;
    tick();
    op_valid = 1'b0; flush = 1'b1;
    #1 chk("fe_exec_stall", op_stall, 1);
    tick();
    chk("fe_wb_done", op_done, 1);
    chk("fe_wb_idx_wdata", index_wdata, 32'h2);
    flush = 1'b0;
    tick();

    // Reset during EXEC of TLBWI
    op_valid = 1'b1; op_code = 2'b10; cp0_index = 32'd6; cp0_entryhi = 32'hFFFF_E000;
    tick();
    op_valid = 1'b0; rst = 1'b0;
    #1;
    chk("rm_exec_wen", w_en, 0);
    chk("rm_exec_stall", op_stall, 0);
    tick();
    rst = 1'b1;
    #1;
    chk("rm_after_done", op_done, 0);
    chk("rm_after_stall", op_stall, 0);
    chk("rm_after_wen", w_en, 0);
    chk("rm_after_idx_wren", index_wren, 0);
    chk("rm_after_ehi_wren", entryhi_wren, 0);
    chk("rm_after_vpn2", s_vpn2, 0);
    chk("rm_after_windex", w_index, 0);
    tick();
    chk("rm_next_done", op_done, 0);
    chk("rm_next_wen", w_en, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
